// File: rtl/mmio_uart_tx_if.sv
// CPU memory-stage bus for the UART transmitter: select, byte address,
// byte-lane write strobes, store data and combinational load data.
interface mmio_uart_tx_if;
  logic        sel;
  logic [3:0]  addr;
  logic [3:0]  w_en;
  logic [31:0] w_data;
  logic [31:0] r_data;

  modport master (output sel, output addr, output w_en, output w_data, input r_data);
  modport slave  (input sel, input addr, input w_en, input w_data, output r_data);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO, a programmable
// baud divisor, a sticky overflow flag and an idle/empty interrupt.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RST   = 16'd16
) (
  input  logic             clk,
  input  logic             rst,
  mmio_uart_tx_if.slave    bus,
  output logic             tx,
  output logic             irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             ovf;
  logic [15:0]      div, div_eff, bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic full, empty, push_req, push, pop, ovf_set, ovf_clr, bit_end, idle_nxt;
  logic [7:0]  status;
  logic [31:0] r_data_c;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = bus.sel && (bus.addr[3:2] == 2'd0) && bus.w_en[0];
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;
  assign ovf_clr  = bus.sel && (bus.addr[3:2] == 2'd1) && bus.w_en[0] && bus.w_data[3];

  assign div_eff  = (div == 16'd0) ? 16'd1 : div;
  // Comparing with >= lets a freshly shrunk divisor end the current bit at once.
  assign bit_end  = (bit_cnt >= div_eff - 16'd1);
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign idle_nxt = empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  assign status = {4'(count), ovf, empty, full, state != IDLE};

  always_comb begin
    r_data_c = '0;
    if (bus.sel) begin
      case (bus.addr[3:2])
        2'd1:    r_data_c = {24'd0, status};
        2'd2:    r_data_c = {16'd0, div};
        default: r_data_c = '0;
      endcase
    end
  end
  assign bus.r_data = r_data_c;

  // NOTE: the byte storage has no reset; pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.w_data[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      div    <= BAUD_RST;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (bus.sel && (bus.addr[3:2] == 2'd2)) begin
        if (bus.w_en[0]) div[7:0]  <= bus.w_data[7:0];
        if (bus.w_en[1]) div[15:8] <= bus.w_data[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      irq     <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      irq <= (count_nxt == '0) && idle_nxt;
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg   <= mem[rd_ptr];
            tx      <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (!empty) begin
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
